// File: rtl/mem_stage_ctrl.sv
// Memory-access stage for the pipelined LC-3b datapath: handshaked word/byte
// loads and stores, two-access indirect ops, variable latency, stall counter.
module mem_stage_ctrl #(
  parameter  int WIDTH  = 16,
  localparam int NLANES = WIDTH / 8,
  localparam int LSB    = $clog2(NLANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [WIDTH-1:0]  in_addr,
  input  logic [WIDTH-1:0]  in_wdata,
  input  logic [WIDTH-1:0]  in_alu,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [NLANES-1:0] mem_byte_enable,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_resp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic              out_is_load,
  output logic [WIDTH-1:0]  stall_cycles
);

  localparam logic [2:0] OP_LDW = 3'd1;
  localparam logic [2:0] OP_LDB = 3'd2;
  localparam logic [2:0] OP_STW = 3'd3;
  localparam logic [2:0] OP_STB = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_STI = 3'd6;

  localparam logic [WIDTH-1:0] WORD_MASK = ~WIDTH'((1 << LSB) - 1);

  typedef enum logic [1:0] {IDLE, ACC1, GAP, ACC2} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [LSB-1:0]      lane_q, lane_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    alu_q, alu_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [NLANES-1:0]   mem_be_q, mem_be_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_result_q, out_result_d;
  logic                out_is_load_q, out_is_load_d;
  logic [WIDTH-1:0]    stall_q, stall_d;
  logic                accept;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_d       = state_q;
    op_d          = op_q;
    lane_d        = lane_q;
    wdata_d       = wdata_q;
    alu_d         = alu_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_is_load_d = out_is_load_q;
    stall_d       = stall_q;

    if (state_q != IDLE && stall_q != '1) stall_d = stall_q + 1'b1;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d     = in_op;
          lane_d   = in_addr[LSB-1:0];
          wdata_d  = in_wdata;
          alu_d    = in_alu;
          mem_be_d = '1;
          state_d  = ACC1;
          case (in_op)
            OP_LDW, OP_LDI, OP_STI: begin
              // Indirect ops always read their pointer word first.
              mem_read_d = 1'b1;
              mem_addr_d = in_addr & WORD_MASK;
            end
            OP_LDB: begin
              mem_read_d = 1'b1;
              mem_addr_d = in_addr;
            end
            OP_STW: begin
              mem_write_d = 1'b1;
              mem_addr_d  = in_addr & WORD_MASK;
              mem_wdata_d = in_wdata;
            end
            OP_STB: begin
              mem_write_d = 1'b1;
              mem_addr_d  = in_addr;
              mem_wdata_d = {NLANES{in_wdata[7:0]}};
              mem_be_d    = NLANES'(1) << in_addr[LSB-1:0];
            end
            default: begin
              state_d       = IDLE;
              out_valid_d   = 1'b1;
              out_result_d  = in_alu;
              out_is_load_d = 1'b0;
            end
          endcase
        end
      end
      ACC1: begin
        if (mem_resp) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = IDLE;
          case (op_q)
            OP_LDI, OP_STI: begin
              // Pointer parks in mem_addr through GAP; requests stay low there.
              mem_addr_d = mem_rdata & WORD_MASK;
              state_d    = GAP;
            end
            OP_LDW: begin
              out_valid_d   = 1'b1;
              out_result_d  = mem_rdata;
              out_is_load_d = 1'b1;
            end
            OP_LDB: begin
              out_valid_d   = 1'b1;
              out_result_d  = {{(WIDTH-8){1'b0}}, mem_rdata[int'(lane_q)*8 +: 8]};
              out_is_load_d = 1'b1;
            end
            default: begin
              out_valid_d   = 1'b1;
              out_result_d  = alu_q;
              out_is_load_d = 1'b0;
            end
          endcase
        end
      end
      GAP: begin
        state_d  = ACC2;
        mem_be_d = '1;
        if (op_q == OP_LDI) begin
          mem_read_d = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          mem_wdata_d = wdata_q;
        end
      end
      ACC2: begin
        if (mem_resp) begin
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          out_is_load_d = (op_q == OP_LDI);
          out_result_d  = (op_q == OP_LDI) ? mem_rdata : alu_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates are non-blocking so every register sees pre-edge values.
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= '0;
      lane_q        <= '0;
      wdata_q       <= '0;
      alu_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_is_load_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      wdata_q       <= wdata_d;
      alu_q         <= alu_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_is_load_q <= out_is_load_d;
      stall_q       <= stall_d;
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign out_valid       = out_valid_q;
  assign out_result      = out_result_q;
  assign out_is_load     = out_is_load_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus randomized ops checked
// against a word-array reference model of LC-3b memory semantics.
module tb_mem_stage_ctrl;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_addr, in_wdata, in_alu;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic        out_valid, out_ready, out_is_load;
  logic [15:0] out_result, stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [15:0] dmem [16];
  logic [15:0] rmem [16];

  typedef struct {
    logic [15:0] res;
    logic        ld;
    logic [15:0] a1, a2, wd1;
    logic [1:0]  be1;
    int          gap, lat;
    logic [15:0] stall;
    bit          held, ok;
  } obs_t;

  mem_stage_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_is_load(out_is_load),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and plays memory with the given latencies until completion.
  task automatic do_op(input logic [2:0] op, input logic [15:0] addr, wd, alu,
                       input int lat1, lat2, output obs_t o);
    int phase, cnt, waitc;
    o = '{res: 16'h0, ld: 1'b0, a1: 16'h0, a2: 16'h0, wd1: 16'h0, be1: 2'b0,
          gap: 0, lat: 0, stall: 16'h0, held: 1'b1, ok: 1'b0};
    in_op = op; in_addr = addr; in_wdata = wd; in_alu = alu; in_valid = 1'b1;
    waitc = 0;
    #1;
    while (!in_ready && waitc < 100) begin
      tick();
      #1;
      waitc++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    phase = 0;
    cnt = 0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      mem_resp  = 1'b0;
      mem_rdata = 16'($urandom);
      if (out_valid) begin
        o.res = out_result; o.ld = out_is_load; o.lat = cyc;
        o.stall = stall_cycles; o.ok = 1'b1;
        break;
      end
      if (mem_read || mem_write) begin
        if (cnt == 0) begin
          if (phase == 0) begin
            o.a1 = mem_addr; o.wd1 = mem_wdata; o.be1 = mem_byte_enable;
          end else begin
            o.a2 = mem_addr;
          end
        end
        cnt++;
        if (cnt == ((phase == 0) ? lat1 : lat2)) begin
          mem_resp  = 1'b1;
          mem_rdata = dmem[mem_addr[4:1]];
          if (mem_write)
            for (int b = 0; b < 2; b++)
              if (mem_byte_enable[b]) dmem[mem_addr[4:1]][8*b +: 8] = mem_wdata[8*b +: 8];
          phase++;
          cnt = 0;
        end
      end else begin
        if (cnt != 0) o.held = 1'b0;
        if (phase == 1) o.gap++;
      end
      tick();
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if ({mem_read, mem_write, out_valid, out_is_load} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {mem_read, mem_write, out_valid, out_is_load}); end
    checks++; if ({mem_addr, mem_wdata, out_result, stall_cycles} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, out_result, stall_cycles}); end
    checks++; if (mem_byte_enable !== 2'b00) begin errors++; $display("FAIL reset_be got %b exp 00", mem_byte_enable); end
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tick();
    rst = 1'b0;
    in_op = 3'd1; in_addr = 16'h0010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_read_before got %b exp 1", mem_read); end
    rst = 1'b1;
    tick();
    checks++; if ({mem_read, out_valid} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got %b exp 00", {mem_read, out_valid}); end
    checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL rst_mid_stall got %h exp 0000", stall_cycles); end
    tick();
    rst = 1'b0;
    mem_resp = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_resp = 1'b0;
    tick();
    checks++; if ({out_valid, mem_read} !== 2'b00) begin errors++; $display("FAIL rst_late_resp got %b exp 00", {out_valid, mem_read}); end
  endtask

  task automatic test_ldb();
    obs_t o;
    rst = 1'b1; tick(); rst = 1'b0;
    dmem[4'hA] = 16'hA7C3;
    do_op(3'd2, 16'h1235, 16'h0, 16'h7777, 3, 1, o);
    checks++; if (!o.ok) begin errors++; $display("FAIL ldb_timeout got 0 exp 1"); end
    checks++; if (o.a1 !== 16'h1235) begin errors++; $display("FAIL ldb_addr got %h exp 1235", o.a1); end
    checks++; if (o.res !== 16'h00A7) begin errors++; $display("FAIL ldb_result got %h exp 00a7", o.res); end
    checks++; if (o.ld !== 1'b1) begin errors++; $display("FAIL ldb_is_load got %b exp 1", o.ld); end
    checks++; if (o.lat != 4) begin errors++; $display("FAIL ldb_latency got %0d exp 4", o.lat); end
    checks++; if (o.stall !== 16'd3) begin errors++; $display("FAIL ldb_stall got %0d exp 3", o.stall); end
  endtask

  task automatic test_stb();
    obs_t o;
    dmem[0] = 16'h1234;
    do_op(3'd4, 16'h2000, 16'h55AA, 16'h0BAD, 3, 1, o);
    checks++; if (o.wd1 !== 16'hAAAA) begin errors++; $display("FAIL stb_wdata got %h exp aaaa", o.wd1); end
    checks++; if (o.be1 !== 2'b01) begin errors++; $display("FAIL stb_be got %b exp 01", o.be1); end
    checks++; if (o.held !== 1'b1) begin errors++; $display("FAIL stb_write_held got %b exp 1", o.held); end
    checks++; if ({o.res, o.ld} !== {16'h0BAD, 1'b0}) begin errors++; $display("FAIL stb_result got %h/%b exp 0bad/0", o.res, o.ld); end
    checks++; if (dmem[0] !== 16'h12AA) begin errors++; $display("FAIL stb_mem got %h exp 12aa", dmem[0]); end
  endtask

  task automatic test_ldi();
    obs_t o;
    dmem[0] = 16'h4002;
    dmem[1] = 16'hBEEF;
    do_op(3'd5, 16'h3001, 16'h0, 16'h0, 1, 1, o);
    checks++; if (o.a1 !== 16'h3000) begin errors++; $display("FAIL ldi_addr1 got %h exp 3000", o.a1); end
    checks++; if (o.gap != 1) begin errors++; $display("FAIL ldi_gap got %0d exp 1", o.gap); end
    checks++; if (o.a2 !== 16'h4002) begin errors++; $display("FAIL ldi_addr2 got %h exp 4002", o.a2); end
    checks++; if (o.res !== 16'hBEEF) begin errors++; $display("FAIL ldi_result got %h exp beef", o.res); end
    checks++; if (o.lat != 4) begin errors++; $display("FAIL ldi_latency got %0d exp 4", o.lat); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    out_ready = 1'b1;
    in_op = 3'd0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v = 16'($urandom);
      in_alu = v;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", k, in_ready); end
      tick();
      checks++; if ({out_valid, out_result} !== {1'b1, v}) begin errors++; $display("FAIL b2b_result[%0d] got %b/%h exp 1/%h", k, out_valid, out_result, v); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_op = 3'd0; in_alu = 16'h1111; in_valid = 1'b1;
    tick();
    in_alu = 16'h2222;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", k, in_ready); end
      checks++; if ({out_valid, out_result} !== {1'b1, 16'h1111}) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h exp 1/1111", k, out_valid, out_result); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_result} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL bp_second got %b/%h exp 1/2222", out_valid, out_result); end
    tick();
  endtask

  task automatic test_random();
    obs_t o;
    logic [2:0]  op;
    logic [15:0] a, wd, alu, exp_res, ptr, exp_a1;
    logic        exp_ld, mem_op;
    int          l1, l2, exp_lat;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dmem[i] = 16'($urandom);
      rmem[i] = dmem[i];
    end
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom); wd = 16'($urandom); alu = 16'($urandom);
      l1 = $urandom_range(1, 4); l2 = $urandom_range(1, 4);
      exp_res = alu; exp_ld = 1'b0; exp_lat = l1 + 1; mem_op = 1'b1;
      exp_a1 = {a[15:1], 1'b0};
      case (op)
        3'd1: begin exp_res = rmem[a[4:1]]; exp_ld = 1'b1; end
        3'd2: begin exp_res = {8'h00, a[0] ? rmem[a[4:1]][15:8] : rmem[a[4:1]][7:0]}; exp_ld = 1'b1; exp_a1 = a; end
        3'd3: rmem[a[4:1]] = wd;
        3'd4: begin
          if (a[0]) rmem[a[4:1]][15:8] = wd[7:0]; else rmem[a[4:1]][7:0] = wd[7:0];
          exp_a1 = a;
        end
        3'd5: begin ptr = rmem[a[4:1]]; exp_res = rmem[ptr[4:1]]; exp_ld = 1'b1; exp_lat = l1 + l2 + 2; end
        3'd6: begin ptr = rmem[a[4:1]]; rmem[ptr[4:1]] = wd; exp_lat = l1 + l2 + 2; end
        default: begin exp_lat = 1; mem_op = 1'b0; end
      endcase
      do_op(op, a, wd, alu, l1, l2, o);
      checks++; if (!o.ok) begin errors++; $display("FAIL rand_timeout[%0d] op %0d got 0 exp 1", n, op); end
      checks++; if ({o.res, o.ld} !== {exp_res, exp_ld}) begin errors++; $display("FAIL rand_result[%0d] op %0d got %h/%b exp %h/%b", n, op, o.res, o.ld, exp_res, exp_ld); end
      checks++; if (o.lat != exp_lat) begin errors++; $display("FAIL rand_latency[%0d] op %0d got %0d exp %0d", n, op, o.lat, exp_lat); end
      if (mem_op) begin
        checks++; if (o.a1 !== exp_a1) begin errors++; $display("FAIL rand_addr[%0d] op %0d got %h exp %h", n, op, o.a1, exp_a1); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (dmem[i] !== rmem[i]) begin errors++; $display("FAIL rand_mem[%0d] got %h exp %h", i, dmem[i], rmem[i]); end
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; tick(); rst = 1'b0;
    in_op = 3'd1; in_addr = 16'h0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    mem_resp = 1'b0;
    repeat (70000) tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_count got %h exp ffff", stall_cycles); end
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL sat_read_held got %b exp 1", mem_read); end
    mem_resp = 1'b1; mem_rdata = 16'h0C0D;
    tick();
    mem_resp = 1'b0;
    checks++; if ({out_valid, out_result} !== {1'b1, 16'h0C0D}) begin errors++; $display("FAIL sat_complete got %b/%h exp 1/0c0d", out_valid, out_result); end
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_no_wrap got %h exp ffff", stall_cycles); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_addr = 16'h0;
    in_wdata = 16'h0; in_alu = 16'h0; mem_rdata = 16'h0; mem_resp = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) dmem[i] = 16'h0;
    test_reset();
    test_ldb();
    test_stb();
    test_ldi();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
